// File: rtl/l2_way_array_pkg.sv
// rtl/l2_way_array_pkg.sv - shared state type and even-parity helper for the L2 way array
package l2_way_array_pkg;

    typedef enum logic {ARR_INIT, ARR_RUN} l2arr_state_e;

    // Widest entry the parity helper covers; callers zero-extend into this width
    localparam int PAR_MAX_W = 64;

    function automatic logic even_par(input logic [PAR_MAX_W-1:0] data, input int width);
        logic p;
        p = 1'b0;
        for (int i = 0; i < PAR_MAX_W; i++) begin
            if (i < width) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/l2_way_array_if.sv
// rtl/l2_way_array_if.sv - write/read/flush bus of the L2 way array
interface l2_way_array_if #(
    parameter int DWTH = 18,
    parameter int AWTH = 3,
    parameter int NWAY = 4
);
    logic                   flush_i;
    logic                   init_busy_o;
    logic                   wen_i;
    logic [NWAY-1:0]        wway_i;
    logic [AWTH-1:0]        waddr_i;
    logic [DWTH-1:0]        wdata_i;
    logic                   ren_i;
    logic [AWTH-1:0]        raddr_i;
    logic                   rvld_o;
    logic [NWAY*DWTH-1:0]   rdata_o;
    logic [NWAY-1:0]        perr_o;

    modport master (
        output flush_i, wen_i, wway_i, waddr_i, wdata_i, ren_i, raddr_i,
        input  init_busy_o, rvld_o, rdata_o, perr_o
    );

    modport slave (
        input  flush_i, wen_i, wway_i, waddr_i, wdata_i, ren_i, raddr_i,
        output init_busy_o, rvld_o, rdata_o, perr_o
    );
endinterface

// File: rtl/l2_way_array_way.sv
// rtl/l2_way_array_way.sv - one way: storage, write port, read mux, parity bit under L2_ARRAY_PARITY_EN
module l2_way_array_way
    import l2_way_array_pkg::*;
#(
    parameter int              DWTH     = 18,
    parameter int              AWTH     = 3,
    parameter int              DEPTH    = 8,
    parameter logic [DWTH-1:0] INIT_VAL = {1'b1, {(DWTH-1){1'b0}}}
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AWTH-1:0] waddr,
    input  logic [DWTH-1:0] wdata,
    input  logic [AWTH-1:0] raddr,
    output logic [DWTH-1:0] rdata,
    output logic            rperr
);

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWTH:0] DEPTH_W = (AWTH+1)'(DEPTH);

    logic [DWTH-1:0] mem [DEPTH];
    logic            wr_ok;
    logic            rd_ok;

    // Addresses past the last entry are dropped on write and read back as INIT_VAL
    assign wr_ok = we && ({1'b0, waddr} < DEPTH_W);
    assign rd_ok = {1'b0, raddr} < DEPTH_W;

    // Data write port
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    assign rdata = rd_ok ? mem[raddr[IW-1:0]] : INIT_VAL;

`ifdef L2_ARRAY_PARITY_EN
    logic par_mem [DEPTH];

    // Parity bit follows every data write, init sweep included
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            par_mem[waddr[IW-1:0]] <= even_par(PAR_MAX_W'(wdata), DWTH);
        end
    end

    assign rperr = rd_ok ? (even_par(PAR_MAX_W'(rdata), DWTH) ^ par_mem[raddr[IW-1:0]]) : 1'b0;
`else
    assign rperr = 1'b0;
`endif

endmodule

// File: rtl/l2_way_array.sv
// rtl/l2_way_array.sv - L2 tag/state way array: init sweep FSM, write-first bypass, read port (L2_ARRAY_PARITY_EN adds parity)
module l2_way_array
    import l2_way_array_pkg::*;
#(
    parameter int              DWTH     = 18,
    parameter int              AWTH     = 3,
    parameter int              DEPTH    = 8,
    parameter int              NWAY     = 4,
    parameter int              RLAT     = 1,
    parameter logic [DWTH-1:0] INIT_VAL = {1'b1, {(DWTH-1){1'b0}}}
) (
    input  logic          clk_i,
    input  logic          rst_i,
    l2_way_array_if.slave bus
);

    localparam logic [AWTH:0]   DEPTH_W  = (AWTH+1)'(DEPTH);
    localparam logic [AWTH-1:0] LAST_PTR = AWTH'(DEPTH - 1);

    l2arr_state_e         state;
    l2arr_state_e         state_nxt;
    logic [AWTH-1:0]      ptr;
    logic [AWTH-1:0]      ptr_nxt;

    logic                 arr_we;
    logic [NWAY-1:0]      arr_wmask;
    logic [AWTH-1:0]      arr_waddr;
    logic [DWTH-1:0]      arr_wdata;
    logic                 rd_act;

    logic [NWAY*DWTH-1:0] way_rdata;
    logic [NWAY-1:0]      way_perr;
    logic [NWAY*DWTH-1:0] rd_data;
    logic [NWAY-1:0]      rd_perr;
    logic                 bypass_hit;

    // State and sweep pointer register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARR_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next state, sweep pointer and steering of the shared array write port
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        arr_we    = 1'b0;
        arr_wmask = bus.wway_i;
        arr_waddr = bus.waddr_i;
        arr_wdata = bus.wdata_i;
        rd_act    = 1'b0;
        case (state)
            ARR_INIT: begin
                arr_we    = 1'b1;
                arr_wmask = '1;
                arr_waddr = ptr;
                arr_wdata = INIT_VAL;
                if (ptr == LAST_PTR) begin
                    state_nxt = ARR_RUN;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + AWTH'(1);
                end
            end
            ARR_RUN: begin
                arr_we = bus.wen_i;
                rd_act = bus.ren_i;
                if (bus.flush_i) begin
                    state_nxt = ARR_INIT;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ARR_INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign bus.init_busy_o = (state == ARR_INIT);

    for (genvar w = 0; w < NWAY; w++) begin : g_way
        l2_way_array_way #(
            .DWTH     (DWTH),
            .AWTH     (AWTH),
            .DEPTH    (DEPTH),
            .INIT_VAL (INIT_VAL)
        ) u_way (
            .clk   (clk_i),
            .we    (arr_we & arr_wmask[w]),
            .waddr (arr_waddr),
            .wdata (arr_wdata),
            .raddr (bus.raddr_i),
            .rdata (way_rdata[w*DWTH +: DWTH]),
            .rperr (way_perr[w])
        );
    end

    // Out-of-range addresses never hit: the write is dropped and the read returns INIT_VAL
    assign bypass_hit = bus.wen_i && (bus.waddr_i == bus.raddr_i) &&
                        ({1'b0, bus.raddr_i} < DEPTH_W);

    // Write-first merge: masked ways return the incoming data with clean parity
    always_comb begin
        rd_data = way_rdata;
        rd_perr = way_perr;
        for (int w = 0; w < NWAY; w++) begin
            if (bypass_hit && bus.wway_i[w]) begin
                rd_data[w*DWTH +: DWTH] = bus.wdata_i;
                rd_perr[w]              = 1'b0;
            end
        end
    end

    if (RLAT == 0) begin : g_rd_comb
        assign bus.rvld_o  = rd_act;
        assign bus.rdata_o = rd_act ? rd_data : '0;
        assign bus.perr_o  = rd_act ? rd_perr : '0;
    end else begin : g_rd_reg
        logic                 rvld_q;
        logic [NWAY*DWTH-1:0] rdata_q;
        logic [NWAY-1:0]      perr_q;

        // One-cycle read pipeline; data holds its last value between reads
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rvld_q  <= 1'b0;
                rdata_q <= '0;
                perr_q  <= '0;
            end else begin
                rvld_q <= rd_act;
                if (rd_act) begin
                    rdata_q <= rd_data;
                    perr_q  <= rd_perr;
                end
            end
        end

        assign bus.rvld_o  = rvld_q;
        assign bus.rdata_o = rdata_q;
        assign bus.perr_o  = rvld_q ? perr_q : '0;
    end

endmodule

// File: tb/tb_l2_way_array.sv
// tb/tb_l2_way_array.sv - directed and randomized checks of l2_way_array against a behavioural model
module tb_l2_way_array;

    localparam int              DWTH = 18;
    localparam int              AWTH = 3;
    localparam int              NWAY = 4;
    localparam int              NI   = 3;
    localparam int              W    = NWAY * DWTH;
    localparam logic [DWTH-1:0] IV   = 18'h20000;
    localparam logic [W-1:0]    IV_ALL = {NWAY{IV}};

    // Instance 0: RLAT 0, depth 8; instance 1: RLAT 1, depth 8; instance 2: RLAT 1, depth 6
    function automatic int dep_of(input int k);
        return (k == 2) ? 6 : 8;
    endfunction

    function automatic int rlat_of(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            wen;
    logic [NWAY-1:0] wway;
    logic [AWTH-1:0] waddr;
    logic [DWTH-1:0] wdata;
    logic            ren;
    logic [AWTH-1:0] raddr;

    always #5 clk = ~clk;

    l2_way_array_if #(.DWTH(DWTH), .AWTH(AWTH), .NWAY(NWAY)) bus0 ();
    l2_way_array_if #(.DWTH(DWTH), .AWTH(AWTH), .NWAY(NWAY)) bus1 ();
    l2_way_array_if #(.DWTH(DWTH), .AWTH(AWTH), .NWAY(NWAY)) bus2 ();

    assign bus0.flush_i = flush; assign bus1.flush_i = flush; assign bus2.flush_i = flush;
    assign bus0.wen_i   = wen;   assign bus1.wen_i   = wen;   assign bus2.wen_i   = wen;
    assign bus0.wway_i  = wway;  assign bus1.wway_i  = wway;  assign bus2.wway_i  = wway;
    assign bus0.waddr_i = waddr; assign bus1.waddr_i = waddr; assign bus2.waddr_i = waddr;
    assign bus0.wdata_i = wdata; assign bus1.wdata_i = wdata; assign bus2.wdata_i = wdata;
    assign bus0.ren_i   = ren;   assign bus1.ren_i   = ren;   assign bus2.ren_i   = ren;
    assign bus0.raddr_i = raddr; assign bus1.raddr_i = raddr; assign bus2.raddr_i = raddr;

    l2_way_array #(.DWTH(DWTH), .AWTH(AWTH), .DEPTH(8), .NWAY(NWAY), .RLAT(0), .INIT_VAL(IV))
        dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    l2_way_array #(.DWTH(DWTH), .AWTH(AWTH), .DEPTH(8), .NWAY(NWAY), .RLAT(1), .INIT_VAL(IV))
        dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    l2_way_array #(.DWTH(DWTH), .AWTH(AWTH), .DEPTH(6), .NWAY(NWAY), .RLAT(1), .INIT_VAL(IV))
        dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    logic            o_busy  [NI];
    logic            o_rvld  [NI];
    logic [W-1:0]    o_rdata [NI];
    logic [NWAY-1:0] o_perr  [NI];

    assign o_busy[0] = bus0.init_busy_o; assign o_rvld[0] = bus0.rvld_o;
    assign o_rdata[0] = bus0.rdata_o;    assign o_perr[0] = bus0.perr_o;
    assign o_busy[1] = bus1.init_busy_o; assign o_rvld[1] = bus1.rvld_o;
    assign o_rdata[1] = bus1.rdata_o;    assign o_perr[1] = bus1.perr_o;
    assign o_busy[2] = bus2.init_busy_o; assign o_rvld[2] = bus2.rvld_o;
    assign o_rdata[2] = bus2.rdata_o;    assign o_perr[2] = bus2.perr_o;

    // Behavioural model: array contents, remaining init cycles, pending registered read
    logic [DWTH-1:0] m [NI][8][NWAY];
    int              busy   [NI] = '{8, 8, 6};
    logic            p_vld  [NI] = '{1'b0, 1'b0, 1'b0};
    logic [W-1:0]    p_last [NI] = '{'0, '0, '0};

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read of raddr returns this cycle: write-first, out of range gives INIT_VAL
    function automatic logic [W-1:0] exp_read(input int k);
        logic [W-1:0] r;
        r = '0;
        for (int w = 0; w < NWAY; w++) begin
            if (int'(raddr) >= dep_of(k))
                r[w*DWTH +: DWTH] = IV;
            else if (wen && (waddr == raddr) && wway[w])
                r[w*DWTH +: DWTH] = wdata;
            else
                r[w*DWTH +: DWTH] = m[k][raddr][w];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                busy[k]   = dep_of(k);
                p_vld[k]  = 1'b0;
                p_last[k] = '0;
            end else if (busy[k] == 0) begin
                p_vld[k] = ren;
                if (ren) p_last[k] = exp_read(k);
                if (wen && int'(waddr) < dep_of(k)) begin
                    for (int w = 0; w < NWAY; w++)
                        if (wway[w]) m[k][waddr][w] = wdata;
                end
                if (flush) busy[k] = dep_of(k);
            end else begin
                p_vld[k] = 1'b0;
                busy[k]  = busy[k] - 1;
                if (busy[k] == 0) begin
                    for (int a = 0; a < 8; a++)
                        for (int w = 0; w < NWAY; w++)
                            m[k][a][w] = IV;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                logic ev;
                check($sformatf("busy%0d", k), W'(o_busy[k]), W'(busy[k] > 0));
                if (rlat_of(k) == 0) begin
                    ev = (busy[k] == 0) && ren;
                    check($sformatf("rvld%0d", k), W'(o_rvld[k]), W'(ev));
                    if (ev) check($sformatf("rdata%0d", k), o_rdata[k], exp_read(k));
                end else begin
                    check($sformatf("rvld%0d", k), W'(o_rvld[k]), W'(p_vld[k]));
                    check($sformatf("rdata%0d", k), o_rdata[k], p_last[k]);
                end
`ifndef L2_ARRAY_PARITY_EN
                check($sformatf("perr%0d", k), W'(o_perr[k]), W'(0));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; wen = 1'b0; wway = '0; waddr = '0; wdata = '0; ren = 1'b0; raddr = '0;
    endtask

    initial begin
        int n;
        bit seen_vld;
        rst = 1'b1;
        idle();
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", W'(o_busy[1]), W'(1));
        check("reset_rvld", W'(o_rvld[1]), W'(0));
        check("reset_rdata", o_rdata[1], '0);

        step(); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_busy[1]) n++; else break;
        end
        check("init_cycles", W'(n), W'(8));

        for (int a = 0; a < 8; a++) begin
            step(); idle(); ren = 1'b1; raddr = AWTH'(a);
            @(negedge clk);
            check("init_rd_rlat0", o_rdata[0], IV_ALL);
            if (a == 0) check("rlat1_latency", W'(o_rvld[1]), W'(0));
            else        check("init_rd_rlat1", o_rdata[1], IV_ALL);
        end
        step(); idle();
        @(negedge clk);
        check("init_rd_last_vld", W'(o_rvld[1]), W'(1));
        check("init_rd_last", o_rdata[1], IV_ALL);

        step(); wen = 1'b1; wway = 4'b0101; waddr = 3'd3; wdata = 18'h00ABC;
        step(); idle(); ren = 1'b1; raddr = 3'd3;
        @(negedge clk);
        check("mask_rd_rlat0", o_rdata[0], {IV, 18'h00ABC, IV, 18'h00ABC});
        step(); idle();
        @(negedge clk);
        check("mask_rd_rlat1", o_rdata[1], {IV, 18'h00ABC, IV, 18'h00ABC});

        step(); wen = 1'b1; wway = 4'b0010; waddr = 3'd5; wdata = 18'h11111; ren = 1'b1; raddr = 3'd5;
        @(negedge clk);
        check("coll_rlat0", o_rdata[0], {IV, IV, 18'h11111, IV});
        step(); idle();
        @(negedge clk);
        check("coll_rlat1_vld", W'(o_rvld[1]), W'(1));
        check("coll_rlat1", o_rdata[1], {IV, IV, 18'h11111, IV});

        step(); flush = 1'b1; wen = 1'b1; wway = 4'hF; waddr = 3'd2; wdata = 18'h3FFFF;
        n = 0;
        seen_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(); idle();
            if (i < 6) begin
                wen = 1'b1; wway = 4'hF; waddr = 3'd2; wdata = 18'h15555; ren = 1'b1; raddr = 3'd2;
            end
            @(negedge clk);
            if (o_busy[1]) begin
                n++;
                if (o_rvld[0] || o_rvld[1]) seen_vld = 1'b1;
            end else break;
        end
        check("flush_cycles", W'(n), W'(8));
        check("flush_no_rvld", W'(seen_vld), W'(0));
        step(); idle(); ren = 1'b1; raddr = 3'd2;
        @(negedge clk);
        check("flush_rd_rlat0", o_rdata[0], IV_ALL);
        step(); idle();
        @(negedge clk);
        check("flush_rd_rlat1", o_rdata[1], IV_ALL);

        step(); rst = 1'b1;
        step(); rst = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step(); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_busy[1]) n++; else break;
        end
        check("rst_mid_sweep_cycles", W'(n), W'(8));

`ifdef L2_ARRAY_PARITY_EN
        step(); idle();
        dut1.g_way[3].u_way.mem[1][0] = ~dut1.g_way[3].u_way.mem[1][0];
        m[1][1][3][0] = ~m[1][1][3][0];
        step(); ren = 1'b1; raddr = 3'd1;
        step(); idle();
        @(negedge clk);
        check("parity_vld", W'(o_rvld[1]), W'(1));
        check("parity_err", W'(o_perr[1]), W'(4'b1000));
        step(); wen = 1'b1; wway = 4'hF; waddr = 3'd1; wdata = 18'h00000;
        step(); idle();
`endif

        for (int c = 0; c < 800; c++) begin
            step();
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            wen   = 1'($urandom_range(0, 1));
            wway  = NWAY'($urandom_range(0, 15));
            waddr = AWTH'($urandom_range(0, 7));
            wdata = DWTH'($urandom);
            ren   = 1'($urandom_range(0, 1));
            raddr = ($urandom_range(0, 3) == 0) ? waddr : AWTH'($urandom_range(0, 7));
        end
        step(); rst = 1'b0; idle();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
